soc_system_mutex_bank: RTL and testbench

- Parametrised bank of NUM_MUTEX hardware mutexes behind one Avalon-MM slave, used for HPS/soft-CPU arbitration of shared resources such as audio buffers and codec registers.
- Keeps the single-mutex value/owner acquire semantics and the first-write reset flag.
- Adds:
  - per-mutex lease timeout with automatic forced release,
  - sticky expiry flags,
  - a maskable release interrupt,
  - registered read data.

---
 rtl/soc_system_mutex_bank.sv | 220 ++++++++++++++++++++++
 tb/tb_soc_system_mutex_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_mutex_bank.sv
// ---------------------------------------------------------------------------
// soc_system_mutex_bank
//
// A bank of NUM_MUTEX hardware mutexes behind one Avalon-MM slave. The HPS
// and soft CPUs use it to arbitrate shared resources such as audio buffers
// and codec registers.
//
// Each mutex holds a 16-bit value and a 16-bit owner tag. A write is
// accepted only when the mutex is free (value == 0) or when the writer's
// owner tag matches. Each mutex also has an optional lease. A lease counter
// is loaded on acquire/renew and forces a release when it runs out. A forced
// release sets a sticky expired flag and a pending flag. Pending flags that
// are enabled in IRQ_EN drive a level interrupt.
//
// Word address map (N = NUM_MUTEX):
//   0..N-1 : MUTEX[i]   [31:16] owner, [15:0] value
//   N      : RESET_FLAG  reads 1 after reset; any write clears it
//   N+1    : LEASE       [LEASE_W-1:0] lease length in cycles, 0 = none
//   N+2    : STATUS      [N-1:0] locked (RO), [16+N-1:16] expired (W1C)
//   N+3    : PENDING     [N-1:0] release-pending flags (W1C)
//   N+4    : IRQ_EN      [N-1:0] interrupt enables (RW)
//   other  : reads 0, writes ignored
//
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset
//   address     word address (ADDR_W bits)
//   chipselect  slave select
//   read        read strobe; readdata is valid one cycle later
//   write       write strobe; takes effect at the edge ending the cycle
//   writedata   32-bit write data
//   readdata    registered read data; holds until the next read
//   irq         level interrupt, |(PENDING & IRQ_EN)
//
// ADDR_W must be large enough that 2^ADDR_W >= NUM_MUTEX + 5.
// ---------------------------------------------------------------------------
module soc_system_mutex_bank #(
  parameter int NUM_MUTEX = 4,
  parameter int LEASE_W   = 24,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] ADDR_RESET_FLAG = ADDR_W'(NUM_MUTEX);
  localparam logic [ADDR_W-1:0] ADDR_LEASE      = ADDR_W'(NUM_MUTEX + 1);
  localparam logic [ADDR_W-1:0] ADDR_STATUS     = ADDR_W'(NUM_MUTEX + 2);
  localparam logic [ADDR_W-1:0] ADDR_PENDING    = ADDR_W'(NUM_MUTEX + 3);
  localparam logic [ADDR_W-1:0] ADDR_IRQ_EN     = ADDR_W'(NUM_MUTEX + 4);

  typedef logic [LEASE_W-1:0] lease_t;

  // Per-mutex state
  logic [15:0]          value_q     [NUM_MUTEX];
  logic [15:0]          value_d     [NUM_MUTEX];
  logic [15:0]          owner_q     [NUM_MUTEX];
  logic [15:0]          owner_d     [NUM_MUTEX];
  lease_t               lease_cnt_q [NUM_MUTEX];
  lease_t               lease_cnt_d [NUM_MUTEX];

  // Bank-wide registers
  lease_t               lease_q,      lease_d;
  logic [NUM_MUTEX-1:0] expired_q,    expired_d;
  logic [NUM_MUTEX-1:0] pending_q,    pending_d;
  logic [NUM_MUTEX-1:0] irq_en_q,     irq_en_d;
  logic                 reset_flag_q, reset_flag_d;
  logic [31:0]          readdata_q,   readdata_d;

  // Decode and event vectors
  logic                 wr_en;
  logic                 rd_en;
  logic [NUM_MUTEX-1:0] locked;
  logic [NUM_MUTEX-1:0] mutex_sel;
  logic [NUM_MUTEX-1:0] exp_set;
  logic [NUM_MUTEX-1:0] pend_set;
  logic [NUM_MUTEX-1:0] exp_clr;
  logic [NUM_MUTEX-1:0] pend_clr;
  logic [31:0]          rd_word;

  assign wr_en = chipselect & write;
  assign rd_en = chipselect & read;

  // Lock state and per-mutex write decode
  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    locked    = '0;
    mutex_sel = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      locked[i]    = (value_q[i] != 16'h0000);
      mutex_sel[i] = wr_en && (address == ADDR_W'(i));
    end
  end

  // Mutex value/owner/lease next state.
  // Every decision uses pre-edge state. So an owner renew in the cycle where
  // the counter sits at 1 reloads the counter before the expiry can happen.
  // A non-owner write in that same cycle still sees the mutex locked and is
  // rejected.
  always_comb begin
    exp_set  = '0;
    pend_set = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      value_d[i]     = value_q[i];
      owner_d[i]     = owner_q[i];
      lease_cnt_d[i] = lease_cnt_q[i];

      if (mutex_sel[i] && (!locked[i] || (owner_q[i] == writedata[31:16]))) begin
        value_d[i] = writedata[15:0];
        owner_d[i] = writedata[31:16];
        if (writedata[15:0] != 16'h0000) begin
          // Acquire or renew. A LEASE of 0 loads 0, which disables the timeout.
          lease_cnt_d[i] = lease_q;
        end else begin
          // Voluntary release.
          lease_cnt_d[i] = '0;
          pend_set[i]    = 1'b1;
        end
      end else if (locked[i] && (lease_cnt_q[i] != '0)) begin
        lease_cnt_d[i] = lease_cnt_q[i] - LEASE_W'(1);
        if (lease_cnt_q[i] == LEASE_W'(1)) begin
          // Lease ran out: forced release.
          value_d[i]  = 16'h0000;
          owner_d[i]  = 16'h0000;
          exp_set[i]  = 1'b1;
          pend_set[i] = 1'b1;
        end
      end
    end
  end

  // Bank-wide control registers. In the W1C flags, a new set wins over a
  // clear in the same cycle.
  always_comb begin
    exp_clr      = '0;
    pend_clr     = '0;
    lease_d      = lease_q;
    irq_en_d     = irq_en_q;
    reset_flag_d = reset_flag_q;

    if (wr_en) begin
      if (address == ADDR_RESET_FLAG) reset_flag_d = 1'b0;
      if (address == ADDR_LEASE)      lease_d      = writedata[LEASE_W-1:0];
      if (address == ADDR_STATUS)     exp_clr      = writedata[16 +: NUM_MUTEX];
      if (address == ADDR_PENDING)    pend_clr     = writedata[NUM_MUTEX-1:0];
      if (address == ADDR_IRQ_EN)     irq_en_d     = writedata[NUM_MUTEX-1:0];
    end

    expired_d = (expired_q & ~exp_clr)  | exp_set;
    pending_d = (pending_q & ~pend_clr) | pend_set;
  end

  // Read mux. The result is captured only on a read, so readdata keeps its
  // value between reads.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      if (address == ADDR_W'(i)) rd_word = {owner_q[i], value_q[i]};
    end
    case (address)
      ADDR_RESET_FLAG: rd_word = {31'b0, reset_flag_q};
      ADDR_LEASE:      rd_word = 32'(lease_q);
      ADDR_STATUS: begin
        rd_word[NUM_MUTEX-1:0]    = locked;
        rd_word[16 +: NUM_MUTEX]  = expired_q;
      end
      ADDR_PENDING:    rd_word[NUM_MUTEX-1:0] = pending_q;
      ADDR_IRQ_EN:     rd_word[NUM_MUTEX-1:0] = irq_en_q;
      default: ;
    endcase
    readdata_d = rd_en ? rd_word : readdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-mutex arrays are small flop arrays, not RAM, so they
      // take the asynchronous reset. This keeps a lease from surviving reset.
      for (int i = 0; i < NUM_MUTEX; i++) begin
        value_q[i]     <= '0;
        owner_q[i]     <= '0;
        lease_cnt_q[i] <= '0;
      end
      lease_q      <= '0;
      expired_q    <= '0;
      pending_q    <= '0;
      irq_en_q     <= '0;
      reset_flag_q <= 1'b1;
      readdata_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_MUTEX; i++) begin
        value_q[i]     <= value_d[i];
        owner_q[i]     <= owner_d[i];
        lease_cnt_q[i] <= lease_cnt_d[i];
      end
      lease_q      <= lease_d;
      expired_q    <= expired_d;
      pending_q    <= pending_d;
      irq_en_q     <= irq_en_d;
      reset_flag_q <= reset_flag_d;
      readdata_q   <= readdata_d;
    end
  end

  assign readdata = readdata_q;

  // Built from flops only. It clears asynchronously with reset because
  // pending_q does.
  assign irq = |(pending_q & irq_en_q);

endmodule

// File: tb/tb_soc_system_mutex_bank.sv
// ---------------------------------------------------------------------------
// tb_soc_system_mutex_bank
//
// Directed self-checking bench for soc_system_mutex_bank with the default
// parameters (4 mutexes, 24-bit lease, 4-bit address). Each read pushes its
// expected word to a scoreboard queue. A monitor pops the queue and compares
// when readdata updates, one cycle later. irq and the in-reset outputs are
// checked directly.
// ---------------------------------------------------------------------------
module tb_soc_system_mutex_bank;

  localparam int N        = 4;
  localparam int A_RF     = N;
  localparam int A_LEASE  = N + 1;
  localparam int A_STATUS = N + 2;
  localparam int A_PEND   = N + 3;
  localparam int A_IRQEN  = N + 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  soc_system_mutex_bank #(.NUM_MUTEX(4), .LEASE_W(24), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        mon_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Read monitor: a read sampled at this edge shows up on readdata just after it.
  always @(posedge clk) begin
    mon_rd = chipselect && read && reset_n;
    #1;
    if (mon_rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", readdata, 32'hDEAD_BEEF);
      end else begin
        check(tag_q.pop_front(), readdata, exp_q.pop_front());
      end
    end
  end

  // Each bus task occupies exactly one clock cycle, starting at a negedge.
  task automatic idle();
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) idle();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b0; write = 1'b1;
    address = 4'(a); writedata = d;
  endtask

  task automatic rd(input int a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0;
    address = 4'(a); writedata = '0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    idle_n(3);
    check("irq_in_reset", {31'b0, irq}, 32'h0);
    check("readdata_in_reset", readdata, 32'h0);
    reset_n = 1'b1;

    // Reset flag and idle mutex
    rd(A_RF, 32'h1, "rf_after_reset");
    wr(A_RF, 32'h0);
    rd(A_RF, 32'h0, "rf_after_write");
    rd(0, 32'h0, "mutex0_reset");

    // Acquire, contention, release
    wr(1, 32'h00AA_0001);
    rd(1, 32'h00AA_0001, "m1_acquire");
    wr(1, 32'h00BB_0005);
    rd(1, 32'h00AA_0001, "m1_contention");
    idle_n(3);
    check("readdata_hold", readdata, 32'h00AA_0001);
    wr(1, 32'h00AA_0000);
    rd(1, 32'h00AA_0000, "m1_release");
    rd(A_STATUS, 32'h0, "status_after_release");
    rd(A_PEND, 32'h2, "pending_after_release");
    wr(A_PEND, 32'h2);
    rd(A_PEND, 32'h0, "pending_w1c");
    rd(15, 32'h0, "unmapped_read");

    // Lease expiry and interrupt: acquire in cycle 0, expiry visible in cycle 6
    wr(A_LEASE, 32'd5);
    wr(A_IRQEN, 32'h4);
    wr(2, 32'h00CC_0001);
    for (int k = 1; k <= 5; k++) begin
      rd(A_STATUS, 32'h0000_0004, $sformatf("m2_locked_c%0d", k));
      check($sformatf("irq_low_c%0d", k), {31'b0, irq}, 32'h0);
    end
    rd(A_STATUS, 32'h0004_0000, "m2_expired_c6");
    check("irq_high_c6", {31'b0, irq}, 32'h1);
    rd(2, 32'h0, "m2_free_after_expiry");
    rd(A_PEND, 32'h4, "pending_after_expiry");
    wr(A_PEND, 32'h4);
    idle();
    check("irq_cleared", {31'b0, irq}, 32'h0);
    rd(A_STATUS, 32'h0004_0000, "expired_sticky");
    wr(A_STATUS, 32'h0004_0000);
    rd(A_STATUS, 32'h0, "expired_w1c");

    // Renew in the expiry cycle: renew wins, held through cycle 6
    wr(A_LEASE, 32'd3);
    wr(3, 32'h00DD_0001);
    idle_n(2);
    wr(3, 32'h00DD_0002);
    for (int k = 4; k <= 6; k++)
      rd(A_STATUS, 32'h0000_0008, $sformatf("renew_held_c%0d", k));
    rd(A_STATUS, 32'h0008_0000, "renew_expired_c7");
    wr(A_STATUS, 32'h0008_0000);
    wr(A_PEND, 32'hF);

    // Non-owner write in the expiry cycle: rejected, free in cycle 4
    wr(3, 32'h00DD_0001);
    idle_n(2);
    wr(3, 32'h00EE_0007);
    rd(A_STATUS, 32'h0008_0000, "nonowner_free_c4");
    rd(3, 32'h0, "nonowner_rejected");
    wr(A_STATUS, 32'h0008_0000);
    wr(A_PEND, 32'hF);

    // LEASE = 0: all four held indefinitely and independently
    wr(A_LEASE, 32'd0);
    for (int i = 0; i < N; i++) wr(i, {16'(i + 1), 16'(i + 1)});
    idle_n(1000);
    rd(A_STATUS, 32'h0000_000F, "all_locked_no_lease");
    rd(A_PEND, 32'h0, "no_pending_no_lease");
    rd(A_LEASE, 32'h0, "lease_reg_zero");
    rd(2, 32'h0003_0003, "m2_held_no_lease");
    for (int i = 0; i < N; i++) wr(i, {16'(i + 1), 16'h0000});
    rd(A_PEND, 32'hF, "pending_all_released");
    rd(A_IRQEN, 32'h4, "irq_en_readback");
    wr(A_PEND, 32'hF);

    // Reset while MUTEX[0] is locked with lease_cnt == 2 (cycle 4 of a 5-lease)
    wr(A_LEASE, 32'd5);
    wr(A_IRQEN, 32'h1);
    wr(0, 32'h0011_0001);
    idle_n(3);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    reset_n = 1'b0;
    #1;
    check("irq_async_reset", {31'b0, irq}, 32'h0);
    check("readdata_async_reset", readdata, 32'h0);
    idle_n(2);
    reset_n = 1'b1;
    idle_n(8);
    rd(0, 32'h0, "m0_after_reset");
    rd(A_PEND, 32'h0, "pending_after_reset");
    rd(A_RF, 32'h1, "rf_after_reset2");
    rd(A_STATUS, 32'h0, "status_after_reset");
    rd(A_IRQEN, 32'h0, "irq_en_after_reset");
    idle();
    check("irq_after_reset", {31'b0, irq}, 32'h0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) idle();
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d reads outstanding, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
